// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//
// Picks one of NUM_SRC test-pattern sources (luma/U/V per pixel) and feeds it
// to the YUV-to-composite modulator. Source changes only happen on frame
// boundaries (newframe). The source either auto-cycles after DWELL_FRAMES
// frames or is chosen manually through a valid/ready handshake.
//
// Optional feature macro: PATTERN_BLANK_EN
//   When defined, every source change passes through a BLANK state that
//   forces black for exactly one full frame before the new source is shown.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   newframe       one-cycle pulse at the first clock of each frame
//   visible_window high while the active picture area is emitted
//   auto_en        1 = auto-cycle sources, 0 = hold current source
//   sel_valid      manual select request
//   sel_idx        requested source index
//   sel_ready      request can be accepted (only while showing)
//   sel_err        one-cycle pulse after an out-of-range index is accepted
//   src_luma/u/v   packed source buses, source i at [8i+7:8i]
//   luma/yuv_u/v   selected pixel, registered (1-cycle latency)
//   pattern_idx    index of the source currently shown, registered
//
// State | meaning
// ------+--------------------------------------------------------------
// WAIT_SYNC | after reset, black output until the first newframe
// SHOW      | normal operation, accepts manual requests, auto-advances
// PENDING   | manual request accepted, waiting for the frame boundary
// BLANK     | (PATTERN_BLANK_EN only) one black frame after a switch
// ---------------------------------------------------------------------------
module pattern_sequencer #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_FRAMES = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   newframe,
  input  logic                   visible_window,
  input  logic                   auto_en,
  input  logic                   sel_valid,
  input  logic [2:0]             sel_idx,
  output logic                   sel_ready,
  output logic                   sel_err,
  input  logic [8*NUM_SRC-1:0]   src_luma,
  input  logic [8*NUM_SRC-1:0]   src_u,
  input  logic [8*NUM_SRC-1:0]   src_v,
  output logic [7:0]             luma,
  output logic [7:0]             yuv_u,
  output logic [7:0]             yuv_v,
  output logic [2:0]             pattern_idx
);

  localparam int              CW       = $clog2(DWELL_FRAMES + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL_FRAMES - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_SRC - 1);

`ifdef PATTERN_BLANK_EN
  typedef enum logic [1:0] {
    S_WAIT_SYNC = 2'd0,
    S_SHOW      = 2'd1,
    S_PENDING   = 2'd2,
    S_BLANK     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_WAIT_SYNC = 2'd0,
    S_SHOW      = 2'd1,
    S_PENDING   = 2'd2
  } state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cur_idx;
  logic [2:0]      w_cur_nxt;
  logic [2:0]      r_pend_idx;
  logic [2:0]      w_pend_nxt;
  logic [CW-1:0]   r_frame_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_err_nxt;
  logic            w_show;
  logic            w_xfer;
  logic            w_sel_ok;
  logic [2:0]      w_cur_inc;

  logic            r_sel_err;
  logic [7:0]      r_luma;
  logic [7:0]      r_u;
  logic [7:0]      r_v;
  logic [2:0]      r_pattern_idx;
  logic [7:0]      w_luma_sel;
  logic [7:0]      w_u_sel;
  logic [7:0]      w_v_sel;

  assign sel_ready = (r_state == S_SHOW);
  assign w_xfer    = sel_valid && sel_ready;
  assign w_sel_ok  = (int'(sel_idx) < NUM_SRC);
  assign w_cur_inc = (r_cur_idx == LAST_IDX) ? 3'd0 : r_cur_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_SYNC;
      r_cur_idx   <= 3'd0;
      r_pend_idx  <= 3'd0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_idx   <= w_cur_nxt;
      r_pend_idx  <= w_pend_nxt;
      r_frame_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_idx;
    w_pend_nxt  = r_pend_idx;
    w_cnt_nxt   = r_frame_cnt;
    w_err_nxt   = 1'b0;
    w_show      = 1'b0;
    case (r_state)
      S_WAIT_SYNC: begin
        if (newframe) w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        w_show = 1'b1;
        if (newframe && auto_en) begin
          if (r_frame_cnt == LAST_CNT) begin
            w_cur_nxt = w_cur_inc;
            w_cnt_nxt = '0;
`ifdef PATTERN_BLANK_EN
            w_state_nxt = S_BLANK;
`endif
          end else begin
            w_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end
        // An accepted request always waits for the next boundary, even if
        // it arrives on a newframe; it also wins the state over an auto
        // blank so the manual choice is never dropped.
        if (w_xfer) begin
          if (w_sel_ok) begin
            w_pend_nxt  = sel_idx;
            w_state_nxt = S_PENDING;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PENDING: begin
        w_show = 1'b1;
        if (newframe) begin
          w_cur_nxt = r_pend_idx;
          w_cnt_nxt = '0;
`ifdef PATTERN_BLANK_EN
          w_state_nxt = S_BLANK;
`else
          w_state_nxt = S_SHOW;
`endif
        end
      end
`ifdef PATTERN_BLANK_EN
      S_BLANK: begin
        // The blank frame does not count toward dwell.
        if (newframe) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHOW;
        end
      end
`endif
      default: w_state_nxt = S_WAIT_SYNC;
    endcase
  end

  // Mux uses the index held during this cycle, so a switch on newframe shows
  // up at the outputs two clocks after the pulse.
  assign w_luma_sel = src_luma[8*r_cur_idx +: 8];
  assign w_u_sel    = src_u[8*r_cur_idx +: 8];
  assign w_v_sel    = src_v[8*r_cur_idx +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_luma        <= 8'd0;
      r_u           <= 8'd0;
      r_v           <= 8'd0;
      r_sel_err     <= 1'b0;
      r_pattern_idx <= 3'd0;
    end else begin
      r_sel_err     <= w_err_nxt;
      r_pattern_idx <= r_cur_idx;
      if (w_show && visible_window) begin
        r_luma <= w_luma_sel;
        r_u    <= w_u_sel;
        r_v    <= w_v_sel;
      end else begin
        r_luma <= 8'd0;
        r_u    <= 8'd0;
        r_v    <= 8'd0;
      end
    end
  end

  assign luma        = r_luma;
  assign yuv_u       = r_u;
  assign yuv_v       = r_v;
  assign sel_err     = r_sel_err;
  assign pattern_idx = r_pattern_idx;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;
  localparam int N  = 4;
  localparam int DW = 2;
`ifdef PATTERN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic newframe = 1'b0, visible_window = 1'b0, auto_en = 1'b0, sel_valid = 1'b0;
  logic [2:0] sel_idx = 3'd0;
  logic sel_ready, sel_err;
  logic [8*N-1:0] src_luma = '0, src_u = '0, src_v = '0;
  logic [7:0] luma, yuv_u, yuv_v;
  logic [2:0] pattern_idx;

  pattern_sequencer #(.NUM_SRC(N), .DWELL_FRAMES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .newframe(newframe), .visible_window(visible_window),
    .auto_en(auto_en), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .sel_ready(sel_ready), .sel_err(sel_err),
    .src_luma(src_luma), .src_u(src_u), .src_v(src_v),
    .luma(luma), .yuv_u(yuv_u), .yuv_v(yuv_v), .pattern_idx(pattern_idx));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: abstract flags rather than a state machine.
  bit m_synced, m_pend_v, m_blank;
  int m_cur, m_cnt, m_pend;
  logic [7:0] sl [N];
  logic [7:0] su [N];
  logic [7:0] sv_ [N];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_pend_v = 0; m_blank = 0;
    m_cur = 0; m_cnt = 0; m_pend = 0;
  endtask

  task automatic cycle(input bit nf, input bit vis, input bit ae, input bit sv, input int si);
    bit rdy, adv;
    logic [7:0] e_l, e_u, e_v;
    int e_pidx;
    bit e_err;
    newframe = nf; visible_window = vis; auto_en = ae; sel_valid = sv; sel_idx = si[2:0];
    for (int i = 0; i < N; i++) begin
      sl[i] = 8'($urandom); su[i] = 8'($urandom); sv_[i] = 8'($urandom);
      src_luma[8*i +: 8] = sl[i]; src_u[8*i +: 8] = su[i]; src_v[8*i +: 8] = sv_[i];
    end
    rdy = m_synced && !m_pend_v && !m_blank;
    chk("sel_ready", {7'd0, sel_ready}, {7'd0, rdy});
    if (m_synced && !m_blank && vis) begin
      e_l = sl[m_cur]; e_u = su[m_cur]; e_v = sv_[m_cur];
    end else begin
      e_l = 8'd0; e_u = 8'd0; e_v = 8'd0;
    end
    e_pidx = m_cur;
    e_err  = rdy && sv && (si >= N);
    if (!m_synced) begin
      if (nf) m_synced = 1;
    end else if (m_blank) begin
      if (nf) begin m_blank = 0; m_cnt = 0; end
    end else if (m_pend_v) begin
      if (nf) begin m_cur = m_pend; m_cnt = 0; m_pend_v = 0; m_blank = BLANK_ON; end
    end else begin
      adv = 0;
      if (nf && ae) begin
        if (m_cnt == DW - 1) begin m_cur = (m_cur + 1) % N; m_cnt = 0; adv = 1; end
        else m_cnt++;
      end
      if (rdy && sv && si < N) begin m_pend_v = 1; m_pend = si; end
      else if (adv) m_blank = BLANK_ON;
    end
    @(posedge clk); #1;
    chk("luma", luma, e_l);
    chk("yuv_u", yuv_u, e_u);
    chk("yuv_v", yuv_v, e_v);
    chk("pattern_idx", {5'd0, pattern_idx}, 8'(e_pidx));
    chk("sel_err", {7'd0, sel_err}, {7'd0, e_err});
  endtask

  // One frame of len cycles; visible for the middle cycles; optional request.
  task automatic frame(input int len, input bit ae, input int req_cyc, input int si);
    for (int c = 0; c < len; c++)
      cycle(c == 0, (c >= 1) && (c < len - 1), ae, c == req_cyc, si);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_luma", luma, 8'd0);
    chk("rst_u", yuv_u, 8'd0);
    chk("rst_v", yuv_v, 8'd0);
    chk("rst_pidx", {5'd0, pattern_idx}, 8'd0);
    chk("rst_ready", {7'd0, sel_ready}, 8'd0);
    chk("rst_err", {7'd0, sel_err}, 8'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    // Visible before any sync: outputs stay black, requests are refused.
    for (int c = 0; c < 3; c++) cycle(0, 1, 1, 1, 2);
    // newframe in WAIT_SYNC with sel_valid high: no acceptance.
    cycle(1, 1, 0, 1, 1);
    for (int c = 0; c < 4; c++) cycle(0, 1, 0, 0, 0);
    // Auto cycling with wrap; pattern_idx checked against dwell arithmetic.
    for (int k = 1; k <= 9; k++) begin
      frame(6, 1, -1, 0);
      chk("auto_seq", {5'd0, pattern_idx}, 8'(((k / DW) % N)));
    end
    // Manual select mid-frame with auto off.
    frame(8, 0, 3, 2);
    frame(8, 0, -1, 0);
    chk("manual_idx", {5'd0, pattern_idx}, 8'd2);
    // Out-of-range request, then a request on the newframe cycle.
    frame(8, 0, 2, 6);
    frame(8, 0, 0, 1);
    chk("nf_req_not_yet", {5'd0, pattern_idx}, 8'd2);
    frame(8, 0, -1, 0);
    chk("nf_req_applied", {5'd0, pattern_idx}, 8'd1);
    // Pending request coinciding with dwell end: manual wins.
    frame(6, 1, -1, 0);
    frame(6, 1, 2, 3);
    frame(6, 1, -1, 0);
    chk("manual_over_auto", {5'd0, pattern_idx}, 8'd3);
    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
      if (c == 1500) do_reset();
    end
    // Reset while a request is pending.
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 3);
    do_reset();
    for (int c = 0; c < 3; c++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    frame(6, 0, -1, 0);
    chk("post_reset_idx", {5'd0, pattern_idx}, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Sequences and multiplexes the test-pattern sources that feed the composite encoder: colour bars, ramps, checkerboards and similar, each providing luma/U/V per pixel. It selects one source, switches only on frame boundaries, and auto-cycles after a programmable dwell or takes manual selection through a valid/ready handshake. It sits between the pattern generators and the YUV-to-composite modulator.

Parameters:
NUM_SRC, 4, number of pattern sources (2..8)
DWELL_FRAMES, 50, frames each pattern is shown in auto mode (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
newframe  in  1  one-cycle pulse at the first clock of each frame
visible_window  in  1  high while the active picture area is being emitted
auto_en  in  1  1 = auto-cycle through sources; 0 = hold the current source
sel_valid  in  1  manual select request
sel_idx  in  3  requested source index
sel_ready  out  1  request can be accepted
sel_err  out  1  one-cycle pulse when an out-of-range sel_idx is accepted
src_luma  in  8*NUM_SRC  packed unsigned luma; source i at [8i+7:8i]
src_u  in  8*NUM_SRC  packed signed U
src_v  in  8*NUM_SRC  packed signed V
luma  out  8  selected luma, unsigned
yuv_u  out  8  selected U, signed
yuv_v  out  8  selected V, signed
pattern_idx  out  3  index of the source currently shown

Behaviour:
- Reset (async assert, sync release): state WAIT_SYNC, cur_idx=0, frame_cnt=0, pend_idx=0, luma=0, yuv_u=0, yuv_v=0, sel_ready=0, sel_err=0, pattern_idx=0.
- States:
  - WAIT_SYNC: outputs black. Goes to SHOW on the first newframe.
  - SHOW: normal operation.
  - PENDING: a manual request has been accepted and waits for the frame boundary.
  - BLANK: exists only with the optional feature.
- sel_ready=1 only in SHOW. A transfer happens when sel_valid && sel_ready.
  - sel_idx < NUM_SRC: latch pend_idx and enter PENDING on the next cycle.
  - sel_idx >= NUM_SRC: the request is consumed and discarded, sel_err pulses 1 cycle, state stays SHOW.
- PENDING, on newframe: cur_idx<=pend_idx, frame_cnt<=0, then SHOW. Requests are not accepted in PENDING.
- A request accepted in the same cycle as newframe takes effect at the following newframe, never the current one.
- Auto mode, in SHOW on newframe with auto_en=1:
  - If frame_cnt==DWELL_FRAMES-1: cur_idx<=(cur_idx==NUM_SRC-1)?0:cur_idx+1 and frame_cnt<=0.
  - Otherwise frame_cnt<=frame_cnt+1.
- auto_en=0: frame_cnt holds its value and cur_idx is frozen.
- A manual switch in PENDING takes priority over auto advance and resets frame_cnt.
- frame_cnt width is $clog2(DWELL_FRAMES+1); it never exceeds DWELL_FRAMES-1.
- Datapath: registered, 1-cycle latency. Each clock:
  - luma/yuv_u/yuv_v <= visible_window ? src[cur_idx] : 0.
  - The mux uses the cur_idx value held during that cycle, so the new source appears from the second clock after the newframe pulse.
- pattern_idx is cur_idx, registered.
- Reset mid-frame or mid-request: pending request lost, outputs black immediately (async), resume in WAIT_SYNC.
- newframe while in WAIT_SYNC with sel_valid high: no acceptance (sel_ready=0).

Optional Feature:
PATTERN_BLANK_EN.
- Defined: every source change (auto or manual) goes through state BLANK for exactly one full frame.
  - cur_idx updates on entry to BLANK.
  - Outputs are forced to 0 during BLANK.
  - On the next newframe: SHOW, frame_cnt=0.
  - The blank frame does not count toward dwell.
  - sel_ready=0 in BLANK.
- Undefined: BLANK state absent; switches go directly to SHOW.

Test Plan:
1. Reset, drive newframe with src0 luma=255/U=0/V=0 and visible_window=1 -> outputs 0 before the first newframe, luma=255 one cycle after visible_window; pattern_idx=0.
2. auto_en=1, DWELL_FRAMES=2, NUM_SRC=4, 9 newframes -> pattern_idx sequence 0,0,1,1,2,2,3,3,0 (wraps); outputs track src[idx] with 1-cycle latency.
3. auto_en=0, sel_idx=2 handshake mid-frame -> sel_ready drops next cycle; pattern_idx stays old until newframe, then 2; sel_ready returns 1.
4. sel_idx=6 with NUM_SRC=4 -> sel_err 1-cycle pulse, pattern_idx unchanged, sel_ready stays 1; request accepted on the same cycle as newframe applies only at the next newframe.
5. Auto advance and pending manual request (sel_idx=3) on the same newframe at dwell end -> pattern_idx=3, frame_cnt=0; visible_window=0 -> outputs 0.
6. With PATTERN_BLANK_EN: a switch yields one frame of luma=0/U=0/V=0 with pattern_idx already new, then the source; assert rst_n low mid-BLANK -> outputs 0 immediately, WAIT_SYNC.
